instr_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Accepts PCs over a valid/ready handshake and issues word reads to instruction memory over a req/gnt port.
- Matches in-order memory responses to their PCs and buffers {pc, instr} pairs in a small FIFO for decode.
- A flush (taken branch) discards buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instr_fetch_sync_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional misaligned-PC faulting is enabled by INSTR_FETCH_MISALIGN_CHECK_EN.
package fetch_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_sync_fifo.sv
// Small synchronous FIFO with flush; head output reads zero when empty.
// Pointers wrap modulo DEPTH, which must be a power of two.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC handshake in, imem req/gnt/rvalid, {pc,instr} FIFO out.
// Define INSTR_FETCH_MISALIGN_CHECK_EN to fault misaligned PCs via if_fault.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_valid,
  output logic             pc_ready,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  output logic             if_fault,
`endif
  output logic [WIDTH-1:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  localparam int DW = 2 * WIDTH + 1;
`else
  localparam int DW = 2 * WIDTH;
`endif

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [CW-1:0]    outstanding_q;
  logic [CW-1:0]    outstanding_d;
  logic [CW-1:0]    drop_cnt_q;
  logic [CW-1:0]    drop_cnt_d;
  logic [CW-1:0]    data_cnt;
  logic [CW-1:0]    tag_cnt;
  logic [CW:0]      credit;
  logic             can_issue;
  logic             misal;
  logic             xfer;
  logic             rsp_take;
  logic             data_push;
  logic             data_pop;
  logic [WIDTH-1:0] tag_pc;
  logic [DW-1:0]    data_din;
  logic [DW-1:0]    data_dout;

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic             mis_acc;
  logic             mis_pend_q;
  logic [WIDTH-1:0] mis_pc_q;

  // A pending fault entry holds a FIFO slot until it is pushed.
  assign misal   = (pc_in[1:0] != 2'b00);
  assign credit  = {1'b0, outstanding_q} + {1'b0, data_cnt}
                 + (CW+1)'(mis_pend_q);
  assign mis_acc = pc_valid && can_issue && misal
                && (outstanding_q == '0)
                && (data_cnt != CW'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_pend_q <= 1'b0;
      mis_pc_q   <= '0;
    end else begin
      mis_pend_q <= mis_acc;
      if (mis_acc) mis_pc_q <= pc_in;
    end
  end

  assign pc_ready  = xfer || mis_acc;
  assign data_push = rsp_take || mis_pend_q;
  assign data_din  = rsp_take ? {1'b0, tag_pc, imem_rdata}
                              : {1'b1, mis_pc_q, WIDTH'(NOP_INSTR)};
  assign if_fault  = data_dout[DW-1];
`else
  assign misal     = 1'b0;
  assign credit    = {1'b0, outstanding_q} + {1'b0, data_cnt};
  assign pc_ready  = xfer;
  assign data_push = rsp_take;
  assign data_din  = {tag_pc, imem_rdata};
`endif

  assign can_issue = !rst && (state_q == RUN) && !flush
                  && (credit < (CW+1)'(FIFO_DEPTH));
  assign imem_req  = pc_valid && can_issue && !misal;
  assign imem_addr = imem_req ? {pc_in[WIDTH-1:2], 2'b00} : '0;
  assign xfer      = imem_req && imem_gnt;

  assign rsp_take  = imem_rvalid && (state_q == RUN) && !flush
                  && (tag_cnt != '0);
  assign data_pop  = if_valid && if_ready && !flush;

  // Every response retires one in-flight request, stale or not.
  assign outstanding_d = outstanding_q + CW'(xfer)
                       - CW'(imem_rvalid && (outstanding_q != '0));

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    priority case (1'b1)
      flush: begin
        drop_cnt_d = outstanding_q - CW'(imem_rvalid);
        state_d    = (drop_cnt_d != '0) ? DRAIN : RUN;
      end
      (state_q == DRAIN) && imem_rvalid: begin
        drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_d == '0) state_d = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .W     (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .din   (pc_in),
    .pop   (rsp_take),
    .flush (flush),
    .dout  (tag_pc),
    .count (tag_cnt)
  );

  sync_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_data_q (
    .clk   (clk),
    .rst   (rst),
    .push  (data_push),
    .din   (data_din),
    .pop   (data_pop),
    .flush (flush),
    .dout  (data_dout),
    .count (data_cnt)
  );

  assign if_valid = (data_cnt != '0);
  assign if_pc    = data_dout[2*WIDTH-1:WIDTH];
  assign if_instr = data_dout[WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard testbench for instr_fetch with a latency-1 imem model.
// Define INSTR_FETCH_MISALIGN_CHECK_EN to also exercise misaligned PCs.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  logic        if_fault;
`endif

  instr_fetch #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    .if_fault    (if_fault),
`endif
    .if_instr    (if_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic        mem_hold;
  int          n_checks;
  int          n_fail;
  int          cyc;

  logic        o_req, o_rdy, o_ifv, o_pop, o_flt;
  logic [31:0] o_addr, o_pc, o_ins;
  int          o_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // One cycle: sample at negedge, then drive imem response after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    o_req  = imem_req;
    o_addr = imem_addr;
    o_rdy  = pc_ready;
    o_ifv  = if_valid;
    o_pc   = if_pc;
    o_ins  = if_instr;
    o_pop  = if_valid && if_ready && !flush;
    o_cyc  = cyc;
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    o_flt  = if_fault;
`else
    o_flt  = 1'b0;
`endif
    if (imem_req && imem_gnt) begin
      mem_q.push_back(imem_addr);
      e.pc    = pc_in;
      e.instr = dat(imem_addr);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!mem_hold && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = dat(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_valid = 1'b1; pc_in = 32'h40;
    imem_gnt = 1'b1; if_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_req got=%b exp=0", o_req); end
    n_checks++;
    if (o_rdy !== 1'b0) begin n_fail++;
      $display("FAIL rst_pc_ready got=%b exp=0", o_rdy); end
    n_checks++;
    if (o_addr !== 32'h0) begin n_fail++;
      $display("FAIL rst_addr got=%h exp=0", o_addr); end
    n_checks++;
    if (o_ifv !== 1'b0) begin n_fail++;
      $display("FAIL rst_if_valid got=%b exp=0", o_ifv); end
    n_checks++;
    if (o_pc !== 32'h0 || o_ins !== 32'h0) begin n_fail++;
      $display("FAIL rst_if_fields got=%h/%h exp=0/0", o_pc, o_ins); end
    n_checks++;
    if (dut.state_q !== RUN || dut.outstanding_q !== '0
        || dut.drop_cnt_q !== '0) begin n_fail++;
      $display("FAIL rst_state got=%0d/%0d/%0d exp=0/0/0",
               dut.state_q, dut.outstanding_q, dut.drop_cnt_q); end
    rst = 1'b0; pc_valid = 1'b0;
    tick();
    n_checks++;
    if (o_ifv !== 1'b0 || o_req !== 1'b0) begin n_fail++;
      $display("FAIL post_rst_idle got=%b/%b exp=0/0", o_ifv, o_req); end
  endtask

  task automatic test_back_to_back();
    int idx = 0, pops = 0, fg = -1, fv = -1;
    exp_t e;
    imem_gnt = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 30 && pops < 4; i++) begin
      pc_valid = (idx < 4);
      pc_in = 32'(idx * 4);
      tick();
      if (o_rdy) begin
        if (fg < 0) fg = o_cyc;
        idx++;
      end
      if (o_ifv && fv < 0) fv = o_cyc;
      if (o_pop) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++;
          $display("FAIL b2b_unexpected got_pc=%h exp=none", o_pc);
        end else begin
          e = exp_q.pop_front();
          if (o_pc !== e.pc || o_ins !== e.instr
              || o_pc !== 32'(pops * 4)) begin n_fail++;
            $display("FAIL b2b_data got=%h/%h exp=%h/%h",
                     o_pc, o_ins, 32'(pops * 4), e.instr);
          end
        end
        pops++;
      end
    end
    pc_valid = 1'b0;
    n_checks++;
    if (pops != 4) begin n_fail++;
      $display("FAIL b2b_count got=%0d exp=4", pops); end
    n_checks++;
    if (fv - fg != 2) begin n_fail++;
      $display("FAIL b2b_latency got=%0d exp=2", fv - fg); end
  endtask

  task automatic test_stall();
    int idx = 0, grants = 0, pops = 0, unstable = 0;
    int resume_addr = -1;
    logic [31:0] head = '0;
    logic seen = 1'b0;
    exp_t e;
    imem_gnt = 1'b1; if_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pc_valid = (idx < 4);
      pc_in = 32'(idx * 4);
      tick();
      if (o_rdy) begin grants++; idx++; end
      if (o_ifv) begin
        if (!seen) begin head = o_pc; seen = 1'b1; end
        else if (o_pc !== head) unstable++;
      end
    end
    n_checks++;
    if (grants != 2) begin n_fail++;
      $display("FAIL stall_grants got=%0d exp=2", grants); end
    n_checks++;
    if (o_rdy !== 1'b0 || o_ifv !== 1'b1) begin n_fail++;
      $display("FAIL stall_flags got=%b/%b exp=0/1", o_rdy, o_ifv); end
    n_checks++;
    if (o_pc !== 32'h0 || unstable != 0) begin n_fail++;
      $display("FAIL stall_head got=%h/%0d exp=0/0", o_pc, unstable); end
    n_checks++;
    if (exp_q.size() != 2 || exp_q[1].pc !== 32'h4) begin n_fail++;
      $display("FAIL stall_held got=%0d exp=2", exp_q.size()); end
    if_ready = 1'b1;
    for (int i = 0; i < 20 && pops < 4; i++) begin
      pc_valid = (idx < 4);
      pc_in = 32'(idx * 4);
      tick();
      if (o_rdy) begin
        if (resume_addr < 0) resume_addr = int'(o_addr);
        idx++;
      end
      if (o_pop) begin
        n_checks++;
        e = exp_q.pop_front();
        if (o_pc !== e.pc || o_ins !== e.instr
            || o_pc !== 32'(pops * 4)) begin n_fail++;
          $display("FAIL stall_data got=%h/%h exp=%h/%h",
                   o_pc, o_ins, e.pc, e.instr);
        end
        pops++;
      end
    end
    pc_valid = 1'b0;
    n_checks++;
    if (resume_addr != 8 || pops != 4) begin n_fail++;
      $display("FAIL stall_resume got=%0d/%0d exp=8/4",
               resume_addr, pops); end
  endtask

  task automatic test_gnt_stall();
    int pops = 0;
    exp_t e;
    imem_gnt = 1'b0; if_ready = 1'b1;
    pc_valid = 1'b1; pc_in = 32'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (o_req !== 1'b1 || o_addr !== 32'h10 || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_wait got=%b/%h/%b exp=1/10/0",
                 o_req, o_addr, o_rdy);
      end
    end
    imem_gnt = 1'b1;
    tick();
    n_checks++;
    if (o_rdy !== 1'b1) begin n_fail++;
      $display("FAIL gnt_xfer got=%b exp=1", o_rdy); end
    pc_valid = 1'b0;
    for (int i = 0; i < 6 && pops < 1; i++) begin
      tick();
      if (o_pop) begin
        n_checks++;
        e = exp_q.pop_front();
        if (o_pc !== 32'h10 || o_ins !== e.instr) begin n_fail++;
          $display("FAIL gnt_data got=%h/%h exp=10/%h",
                   o_pc, o_ins, e.instr);
        end
        pops++;
      end
    end
    n_checks++;
    if (pops != 1) begin n_fail++;
      $display("FAIL gnt_timeout got=%0d exp=1", pops); end
  endtask

  task automatic test_flush_drain();
    int g = 0, pops = 0, stale = 0;
    exp_t e;
    imem_gnt = 1'b1; if_ready = 1'b1; mem_hold = 1'b1;
    for (int i = 0; i < 6 && g < 2; i++) begin
      pc_valid = 1'b1;
      pc_in = 32'h20 + 32'(g * 4);
      tick();
      if (o_rdy) g++;
    end
    pc_in = 32'h100; flush = 1'b1;
    tick();
    n_checks++;
    if (o_req !== 1'b0 || o_rdy !== 1'b0) begin n_fail++;
      $display("FAIL flush_block got=%b/%b exp=0/0", o_req, o_rdy); end
    exp_q.delete();
    flush = 1'b0;
    n_checks++;
    if (dut.state_q !== DRAIN || dut.drop_cnt_q !== 2'd2) begin n_fail++;
      $display("FAIL flush_drop got=%0d/%0d exp=1/2",
               dut.state_q, dut.drop_cnt_q); end
    tick();
    n_checks++;
    if (o_req !== 1'b0 || o_ifv !== 1'b0) begin n_fail++;
      $display("FAIL drain_idle got=%b/%b exp=0/0", o_req, o_ifv); end
    mem_hold = 1'b0;
    for (int i = 0; i < 15 && pops < 1; i++) begin
      tick();
      if (o_rdy) pc_valid = 1'b0;
      if (o_ifv && o_pc !== 32'h100) stale++;
      if (o_pop && o_pc === 32'h100) begin
        n_checks++;
        e = exp_q.pop_front();
        if (o_ins !== e.instr || o_ins !== dat(32'h100)) begin n_fail++;
          $display("FAIL drain_data got=%h exp=%h", o_ins, dat(32'h100));
        end
        pops++;
      end
    end
    pc_valid = 1'b0;
    n_checks++;
    if (pops != 1 || stale != 0) begin n_fail++;
      $display("FAIL drain_resume got=%0d/%0d exp=1/0", pops, stale); end
  endtask

  task automatic test_flush_rvalid();
    int g = 0, pops = 0, stale = 0;
    exp_t e;
    imem_gnt = 1'b1; if_ready = 1'b1; mem_hold = 1'b1;
    for (int i = 0; i < 6 && g < 2; i++) begin
      pc_valid = 1'b1;
      pc_in = 32'h40 + 32'(g * 4);
      tick();
      if (o_rdy) g++;
    end
    pc_valid = 1'b0;
    mem_hold = 1'b0;
    tick();
    flush = 1'b1; mem_hold = 1'b1;
    tick();
    exp_q.delete();
    flush = 1'b0;
    n_checks++;
    if (dut.state_q !== DRAIN || dut.drop_cnt_q !== 2'd1
        || if_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_rv got=%0d/%0d/%b exp=1/1/0",
               dut.state_q, dut.drop_cnt_q, if_valid); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (dut.state_q !== DRAIN || dut.drop_cnt_q !== 2'd1) begin n_fail++;
      $display("FAIL reflush got=%0d/%0d exp=1/1",
               dut.state_q, dut.drop_cnt_q); end
    mem_hold = 1'b0;
    pc_valid = 1'b1; pc_in = 32'h200;
    for (int i = 0; i < 15 && pops < 1; i++) begin
      tick();
      if (o_rdy) pc_valid = 1'b0;
      if (o_ifv && o_pc !== 32'h200) stale++;
      if (o_pop && o_pc === 32'h200) begin
        n_checks++;
        e = exp_q.pop_front();
        if (o_ins !== e.instr) begin n_fail++;
          $display("FAIL reflush_data got=%h exp=%h", o_ins, e.instr);
        end
        pops++;
      end
    end
    pc_valid = 1'b0;
    n_checks++;
    if (pops != 1 || stale != 0) begin n_fail++;
      $display("FAIL reflush_resume got=%0d/%0d exp=1/0", pops, stale); end
  endtask

`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int pops = 0;
    exp_t e;
    imem_gnt = 1'b1; if_ready = 1'b1;
    pc_valid = 1'b1; pc_in = 32'h6;
    tick();
    n_checks++;
    if (o_req !== 1'b0 || o_rdy !== 1'b1) begin n_fail++;
      $display("FAIL mis_accept got=%b/%b exp=0/1", o_req, o_rdy); end
    e.pc = 32'h6; e.instr = NOP_INSTR;
    exp_q.push_front(e);
    pc_in = 32'h8;
    for (int i = 0; i < 12 && pops < 2; i++) begin
      tick();
      if (o_rdy) pc_valid = 1'b0;
      if (o_pop) begin
        n_checks++;
        e = exp_q.pop_front();
        if (o_pc !== e.pc || o_ins !== e.instr
            || o_flt !== (e.pc == 32'h6)) begin n_fail++;
          $display("FAIL mis_data got=%h/%h/%b exp=%h/%h",
                   o_pc, o_ins, o_flt, e.pc, e.instr);
        end
        pops++;
      end
    end
    pc_valid = 1'b0;
    n_checks++;
    if (pops != 2) begin n_fail++;
      $display("FAIL mis_count got=%0d exp=2", pops); end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    mem_hold = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_gnt_stall();
    test_flush_drain();
    test_flush_rvalid();
`ifdef INSTR_FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++;
      $display("FAIL leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
